conv_window_sequencer: RTL
==========================

Name: conv_window_sequencer

Overview:
Upstream feeder and controller for the 4x4 convolution datapath (multiplier array, L1–L4 adder tree, registered conv_out). It loads a 16-byte filter, accepts a row-major 8-bit pixel stream, and forms every stride-1 4x4 window using IMG_W-deep line buffers. It presents each window on input_matrix_reg alongside the held filter_matrix_reg, and drives the staged mul/L1–L4 enables plus conv_valid aligned to the datapath's registered conv_out.

Parameters:
IMG_W, 28, image width in pixels (>=4)
IMG_H, 28, image height in pixels (>=4)
CNT_W, 10, width of win_row/win_col/pixel counters (must hold max(IMG_W,IMG_H))

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when IDLE
filt_valid  in  1  filter byte valid
filt_data  in  8  filter byte; beat k -> filter element k
filt_ready  out  1  high in LOAD_FILTER
pix_valid  in  1  pixel valid
pix_data  in  8  pixel, row-major
pix_ready  out  1  high in STREAM
input_matrix_reg  out  128  current window; element (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)]
filter_matrix_reg  out  128  loaded filter, same packing
mul_enable  out  1  window valid this cycle
l1_add_enable  out  1  mul_enable delayed 1 cycle
l2_add_enable  out  1  delayed 2
l3_add_enable  out  1  delayed 3
l4_add_enable  out  1  delayed 4
conv_valid  out  1  delayed 6; datapath conv_out valid this cycle
win_row  out  CNT_W  top-row index of window on mul_enable
win_col  out  CNT_W  left-col index of window on mul_enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, counters/line buffers/window/filter registers cleared, enable shift chain flushed. Reset mid-frame discards the frame; no done pulse.
- States: IDLE -> (start) LOAD_FILTER -> (16th filter beat accepted) STREAM -> (last pixel accepted) DRAIN -> (6 cycles elapsed) DONE -> IDLE.
- start is ignored outside IDLE.
- LOAD_FILTER: a beat is accepted when filt_valid && filt_ready. Beat k (0..15) writes filter element k, bits [8k+7:8k]. filter_matrix_reg holds its value until the next frame's load.
- STREAM: a pixel is accepted when pix_valid && pix_ready; pix_ready=1 for the whole state. Column counter wraps IMG_W-1 -> 0 and increments the row counter. Line buffers keep the previous 3 rows. The 4x4 window shift register updates on each accept: row 3 takes the new pixel, rows 0–2 take the line-buffer taps.
- Window issue: accepting pixel (row>=3, col>=3) asserts mul_enable in the next cycle, with input_matrix_reg = window rows row-3..row and cols col-3..col; element (3,3) is the accepted pixel. win_row=row-3, win_col=col-3.
- input_matrix_reg holds until the next accept; mul_enable is 1 cycle per window. Pixels at col<3 or row<3 update buffers only.
- Window count per frame is (IMG_W-3)*(IMG_H-3).
- Enable chain: a 6-stage shift register fed by mul_enable. Taps 1–4 drive l1..l4_add_enable; tap 6 drives conv_valid (L4 result is captured into conv_out at the end of the l4 cycle +1). Back-to-back windows give back-to-back enables. The chain is independent of pix_valid gaps.
- DRAIN: pix_ready=0, filt_ready=0. A 3-bit counter runs 6 cycles after the last accept so the final conv_valid has fired before DONE.
- DONE: done=1 for exactly one cycle, then IDLE with busy=0.
- Pixels or filter beats offered in the wrong state are not accepted (ready low) and have no effect.

Test Plan:
- IMG_W=6, IMG_H=5, filter beats all 1, pix_data=index 0..29, no gaps -> 6 mul_enable pulses; the first follows the accept of pixel 21 with win_row=0, win_col=0, input_matrix_reg bytes {0,1,2,3,6,7,8,9,12,13,14,15,18,19,20,21} (element 0 = 0 in [7:0]). Through the datapath, conv_out=168 when conv_valid.
- Same frame: l1..l4_add_enable at +1..+4 and conv_valid at +6 relative to each mul_enable. conv_valid count=6. done one cycle after the DRAIN counter expires; busy 0 the next cycle.
- Random pix_valid gaps (50% duty) -> identical window contents and order as the gapless run; enables keep fixed spacing to their own mul_enable.
- Filter beats 0x10..0x1F with filt_valid toggling -> filter_matrix_reg=0x1F1E..1110, filt_ready drops after beat 16, STREAM entered next cycle; extra filt_valid ignored.
- Assert reset mid-STREAM after 15 pixels -> all outputs 0 immediately (async), no done. A new start+load+frame then produces correct first window (no stale line-buffer data).
- start pulsed during STREAM -> ignored, frame completes normally with exactly (IMG_W-3)*(IMG_H-3) windows.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: loads a 16-byte filter, buffers a row-major pixel
// stream in IMG_W-deep line buffers, issues every stride-1 4x4 window and
// drives the staged enables of the downstream multiply/adder-tree datapath.
module conv_window_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               filt_valid,
    input  logic [7:0]         filt_data,
    output logic               filt_ready,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    output logic               pix_ready,
    output logic [127:0]       input_matrix_reg,
    output logic [127:0]       filter_matrix_reg,
    output logic               mul_enable,
    output logic               l1_add_enable,
    output logic               l2_add_enable,
    output logic               l3_add_enable,
    output logic               l4_add_enable,
    output logic               conv_valid,
    output logic [CNT_W-1:0]   win_row,
    output logic [CNT_W-1:0]   win_col,
    output logic               busy,
    output logic               done
);

    localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILTER,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_filt_cnt;
    logic [CNT_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_col;
    logic [2:0]         r_drain_cnt;
    logic [127:0]       r_filt;
    logic [127:0]       r_win;
    logic [23:0]        r_lb [IMG_W];
    logic               r_mul_en;
    logic [5:0]         r_chain;
    logic [CNT_W-1:0]   r_win_row;
    logic [CNT_W-1:0]   r_win_col;

    logic               w_filt_acc;
    logic               w_pix_acc;
    logic               w_last_pix;
    logic               w_issue;
    logic [LB_AW-1:0]   w_lb_idx;
    logic [23:0]        w_tap;

    // Handshake qualifiers and line-buffer tap for the current column.
    // Tap byte 0 = row-3, byte 1 = row-2, byte 2 = row-1 at this column.
    assign w_filt_acc = filt_valid && (r_state == S_LOAD_FILTER);
    assign w_pix_acc  = pix_valid && (r_state == S_STREAM);
    assign w_last_pix = (r_row == CNT_W'(IMG_H - 1)) && (r_col == CNT_W'(IMG_W - 1));
    assign w_issue    = w_pix_acc && (r_row >= CNT_W'(3)) && (r_col >= CNT_W'(3));
    assign w_lb_idx   = r_col[LB_AW-1:0];
    assign w_tap      = r_lb[w_lb_idx];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values regardless of block order.
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_next     = r_state;
        filt_ready = 1'b0;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LOAD_FILTER;
            end
            S_LOAD_FILTER: begin
                filt_ready = 1'b1;
                if (w_filt_acc && (r_filt_cnt == 4'd15)) w_next = S_STREAM;
            end
            S_STREAM: begin
                pix_ready = 1'b1;
                if (w_pix_acc && w_last_pix) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold until the last window has walked the whole 6-stage
                // enable chain, so its conv_valid lands inside DRAIN.
                if (r_drain_cnt == 3'd6) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Filter load, pixel/drain counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_cnt  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_drain_cnt <= '0;
            r_filt      <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_filt_cnt <= '0;
                r_row      <= '0;
                r_col      <= '0;
            end
            if (w_filt_acc) begin
                r_filt[{r_filt_cnt, 3'b000} +: 8] <= filt_data;
                r_filt_cnt                        <= r_filt_cnt + 4'd1;
            end
            if (w_pix_acc) begin
                if (r_col == CNT_W'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
            end
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Line buffers and the 4x4 window shift register advance on each accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the line buffers are cleared on reset so a restarted frame
            // can never observe bytes left over from an aborted one.
            for (int i = 0; i < IMG_W; i++) r_lb[i] <= '0;
            r_win <= '0;
        end else if (w_pix_acc) begin
            r_lb[w_lb_idx] <= {pix_data, w_tap[23:16], w_tap[15:8]};
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[8*(4*r+c) +: 8] <= r_win[8*(4*r+c+1) +: 8];
                end
            end
            r_win[8*3  +: 8] <= w_tap[7:0];
            r_win[8*7  +: 8] <= w_tap[15:8];
            r_win[8*11 +: 8] <= w_tap[23:16];
            r_win[8*15 +: 8] <= pix_data;
        end
    end

    // Window issue and the enable chain that tracks the datapath pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_en  <= 1'b0;
            r_chain   <= '0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else begin
            r_mul_en <= w_issue;
            r_chain  <= {r_chain[4:0], r_mul_en};
            if (w_issue) begin
                r_win_row <= r_row - CNT_W'(3);
                r_win_col <= r_col - CNT_W'(3);
            end
        end
    end

    assign input_matrix_reg  = r_win;
    assign filter_matrix_reg = r_filt;
    assign mul_enable        = r_mul_en;
    assign l1_add_enable     = r_chain[0];
    assign l2_add_enable     = r_chain[1];
    assign l3_add_enable     = r_chain[2];
    assign l4_add_enable     = r_chain[3];
    assign conv_valid        = r_chain[5];
    assign win_row           = r_win_row;
    assign win_col           = r_win_col;

endmodule
